// File: rtl/ovc_credit_allocator.sv
// Per-output-port VC allocator with downstream credit tracking.
// Grants one fully-drained free VC per head request; releases on tail.
module ovc_credit_allocator #(
   parameter int V  = 4,
   parameter int B  = 4,
   parameter int Bw = $clog2(B + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   input  logic [V-1:0] candidate_ovcs,
   input  logic [V-1:0] vc_pririty,
   output logic         grant_valid,
   output logic [V-1:0] grant_ovc,
   input  logic         flit_sent,
   input  logic [V-1:0] flit_sent_ovc,
   input  logic         flit_sent_tail,
   input  logic [V-1:0] credit_in,
   output logic [V-1:0] ovc_avb,
   output logic [V-1:0] ovc_is_free,
   output logic         credit_err
);

   localparam int PW = (V > 1) ? $clog2(V) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state, state_n;
   logic [Bw-1:0]     cnt   [V];
   logic [Bw-1:0]     cnt_n [V];
   logic signed [Bw+1:0] nxt [V];
   logic [V-1:0]      free_q, free_n;
   logic [V-1:0]      full, elig, pref, arb_mask;
   logic [V-1:0]      pick, grant_q;
   logic [PW-1:0]     ptr, ptr_n;
   logic              pick_any, do_grant;
   logic              cnt_err, err_n;
   int                j;

   always_comb begin
      for (int k = 0; k < V; k++) begin
         full[k]    = (cnt[k] == Bw'(B));
         ovc_avb[k] = (cnt[k] != '0);
      end
   end

   assign ovc_is_free = free_q;
   assign elig        = candidate_ovcs & free_q & full;
   assign pref        = elig & vc_pririty;
   assign arb_mask    = (pref != '0) ? pref : elig;

   // Round-robin search starting at ptr, wrapping modulo V.
   always_comb begin
      pick     = '0;
      pick_any = 1'b0;
      ptr_n    = ptr;
      j        = 0;
      for (int i = 0; i < V; i++) begin
         j = (int'(ptr) + i) % V;
         if (!pick_any && arb_mask[j]) begin
            pick_any = 1'b1;
            pick[j]  = 1'b1;
            ptr_n    = PW'((j + 1) % V);
         end
      end
   end

   always_comb begin
      state_n  = state;
      do_grant = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid && pick_any) begin
               do_grant = 1'b1;
               state_n  = GRANT;
            end
         end
         GRANT:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   assign grant_valid = (state == GRANT);
   assign grant_ovc   = grant_valid ? grant_q : '0;

   // Saturating credit update; out-of-range results flag an error.
   always_comb begin
      cnt_err = 1'b0;
      for (int k = 0; k < V; k++) begin
         nxt[k] = $signed({2'b00, cnt[k]})
                + $signed({{(Bw + 1){1'b0}}, credit_in[k]})
                - $signed({{(Bw + 1){1'b0}}, flit_sent & flit_sent_ovc[k]});
         if (nxt[k] < 0) begin
            cnt_n[k] = '0;
            cnt_err  = 1'b1;
         end else if (nxt[k] > $signed((Bw + 2)'(B))) begin
            cnt_n[k] = Bw'(B);
            cnt_err  = 1'b1;
         end else begin
            cnt_n[k] = nxt[k][Bw-1:0];
         end
      end
   end

   always_comb begin
      free_n = free_q;
      if (flit_sent && flit_sent_tail) free_n = free_n | flit_sent_ovc;
      if (do_grant) free_n = free_n & ~pick;
      err_n = credit_err | cnt_err
            | (flit_sent & (|(flit_sent_ovc & free_q)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < V; k++) cnt[k] <= Bw'(B);
         free_q     <= '1;
         ptr        <= '0;
         grant_q    <= '0;
         credit_err <= 1'b0;
      end else begin
         for (int k = 0; k < V; k++) cnt[k] <= cnt_n[k];
         free_q     <= free_n;
         credit_err <= err_n;
         if (do_grant) begin
            grant_q <= pick;
            ptr     <= ptr_n;
         end
      end
   end

endmodule

// File: tb/tb_ovc_credit_allocator.sv
// Directed-vector bench for ovc_credit_allocator (V=4, B=4).
// Table of per-cycle stimulus/expectations plus multi-cycle sequences.
module tb_ovc_credit_allocator;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic [3:0] candidate_ovcs, vc_pririty;
   logic       grant_valid;
   logic [3:0] grant_ovc;
   logic       flit_sent;
   logic [3:0] flit_sent_ovc;
   logic       flit_sent_tail;
   logic [3:0] credit_in;
   logic [3:0] ovc_avb, ovc_is_free;
   logic       credit_err;

   int total = 0;
   int bad   = 0;

   ovc_credit_allocator #(.V(4), .B(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .candidate_ovcs (candidate_ovcs),
      .vc_pririty     (vc_pririty),
      .grant_valid    (grant_valid),
      .grant_ovc      (grant_ovc),
      .flit_sent      (flit_sent),
      .flit_sent_ovc  (flit_sent_ovc),
      .flit_sent_tail (flit_sent_tail),
      .credit_in      (credit_in),
      .ovc_avb        (ovc_avb),
      .ovc_is_free    (ovc_is_free),
      .credit_err     (credit_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       req;
      logic [3:0] cand;
      logic [3:0] pri;
      logic       fs;
      logic [3:0] fovc;
      logic       ft;
      logic [3:0] cr;
      logic       gv;
      logic [3:0] go;
      logic [3:0] avb;
      logic [3:0] fr;
      logic       err;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(
      logic req, logic [3:0] cand, logic [3:0] pri,
      logic fs, logic [3:0] fovc, logic ft, logic [3:0] cr,
      logic gv, logic [3:0] go, logic [3:0] avb,
      logic [3:0] fr, logic err);
      vec_t v;
      v.req = req; v.cand = cand; v.pri = pri;
      v.fs = fs; v.fovc = fovc; v.ft = ft; v.cr = cr;
      v.gv = gv; v.go = go; v.avb = avb; v.fr = fr; v.err = err;
      return v;
   endfunction

   task automatic check(string name, int idx,
                        logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h expected %0h",
                  name, idx, act, exp);
      end
   endtask

   task automatic check_all(string tag, int idx, logic gv,
                            logic [3:0] go, logic [3:0] avb,
                            logic [3:0] fr, logic err);
      check({tag, ".grant_valid"}, idx, 32'(grant_valid), 32'(gv));
      check({tag, ".grant_ovc"},   idx, 32'(grant_ovc),   32'(go));
      check({tag, ".ovc_avb"},     idx, 32'(ovc_avb),     32'(avb));
      check({tag, ".ovc_is_free"}, idx, 32'(ovc_is_free), 32'(fr));
      check({tag, ".credit_err"},  idx, 32'(credit_err),  32'(err));
   endtask

   task automatic idle_inputs();
      req_valid = 0; candidate_ovcs = 0; vc_pririty = 0;
      flit_sent = 0; flit_sent_ovc = 0; flit_sent_tail = 0;
      credit_in = 0;
   endtask

   task automatic drive(logic req, logic [3:0] cand, logic [3:0] pri,
                        logic fs, logic [3:0] fovc, logic ft,
                        logic [3:0] cr);
      req_valid = req; candidate_ovcs = cand; vc_pririty = pri;
      flit_sent = fs; flit_sent_ovc = fovc; flit_sent_tail = ft;
      credit_in = cr;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      idle_inputs();
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   initial begin
      // req cand pri fs fovc ft cr | gv go avb fr err
      tbl[0]  = mk(1, 4'b0110, 4'b0000, 0, 4'b0000, 0, 4'b0000,
                   1, 4'b0010, 4'b1111, 4'b1101, 0);
      tbl[1]  = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000,
                   0, 4'b0000, 4'b1111, 4'b1101, 0);
      tbl[2]  = mk(1, 4'b1111, 4'b1000, 0, 4'b0000, 0, 4'b0000,
                   1, 4'b1000, 4'b1111, 4'b0101, 0);
      tbl[3]  = mk(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 4'b0000,
                   0, 4'b0000, 4'b1111, 4'b0101, 0);
      tbl[4]  = mk(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 4'b0000,
                   1, 4'b0001, 4'b1111, 4'b0100, 0);
      tbl[5]  = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000,
                   0, 4'b0000, 4'b1111, 4'b0100, 0);
      tbl[6]  = mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 0, 4'b0000,
                   0, 4'b0000, 4'b1111, 4'b0100, 0);
      tbl[7]  = mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 0, 4'b0000,
                   0, 4'b0000, 4'b1111, 4'b0100, 0);
      tbl[8]  = mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 0, 4'b0000,
                   0, 4'b0000, 4'b1111, 4'b0100, 0);
      tbl[9]  = mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 0, 4'b0000,
                   0, 4'b0000, 4'b1101, 4'b0100, 0);
      tbl[10] = mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 0, 4'b0010,
                   0, 4'b0000, 4'b1101, 4'b0100, 0);
      tbl[11] = mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 0, 4'b0000,
                   0, 4'b0000, 4'b1101, 4'b0100, 1);
      tbl[12] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0010,
                   0, 4'b0000, 4'b1111, 4'b0100, 1);
      tbl[13] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0010,
                   0, 4'b0000, 4'b1111, 4'b0100, 1);
      tbl[14] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0010,
                   0, 4'b0000, 4'b1111, 4'b0100, 1);
      tbl[15] = mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 1, 4'b0000,
                   0, 4'b0000, 4'b1111, 4'b0110, 1);
      tbl[16] = mk(1, 4'b0010, 4'b0000, 0, 4'b0000, 0, 4'b0010,
                   0, 4'b0000, 4'b1111, 4'b0110, 1);
      tbl[17] = mk(1, 4'b0010, 4'b0000, 0, 4'b0000, 0, 4'b0010,
                   0, 4'b0000, 4'b1111, 4'b0110, 1);
      tbl[18] = mk(1, 4'b0010, 4'b0000, 0, 4'b0000, 0, 4'b0000,
                   1, 4'b0010, 4'b1111, 4'b0100, 1);
      tbl[19] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000,
                   0, 4'b0000, 4'b1111, 4'b0100, 1);

      idle_inputs();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      check_all("reset", 0, 0, 4'b0000, 4'b1111, 4'b1111, 0);

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].req, tbl[i].cand, tbl[i].pri, tbl[i].fs,
               tbl[i].fovc, tbl[i].ft, tbl[i].cr);
         check_all("vec", i, tbl[i].gv, tbl[i].go, tbl[i].avb,
                   tbl[i].fr, tbl[i].err);
      end

      // Reset lands while grant_valid is high.
      drive(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 4'b0000);
      check_all("pre_rst", 0, 1, 4'b0100, 4'b1111, 4'b0000, 1);
      #2;
      reset = 1;
      #1;
      check_all("async_rst", 0, 0, 4'b0000, 4'b1111, 4'b1111, 0);
      idle_inputs();
      @(posedge clk);
      #1;
      reset = 0;

      // Back-to-back round robin from ptr=0.
      drive(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 4'b0000);
      check_all("rr", 0, 1, 4'b0001, 4'b1111, 4'b1110, 0);
      drive(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 4'b0000);
      check_all("rr", 1, 0, 4'b0000, 4'b1111, 4'b1110, 0);
      drive(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 4'b0000);
      check_all("rr", 2, 1, 4'b0010, 4'b1111, 4'b1100, 0);
      drive(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000);
      check_all("rr", 3, 0, 4'b0000, 4'b1111, 4'b1100, 0);

      // Credit overflow at cnt=B.
      pulse_reset();
      drive(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0001);
      check_all("ovf", 0, 0, 4'b0000, 4'b1111, 4'b1111, 1);

      // Send on a free VC: error, counter still drops, blocks grant.
      pulse_reset();
      drive(0, 4'b0000, 4'b0000, 1, 4'b0100, 0, 4'b0000);
      check_all("free_send", 0, 0, 4'b0000, 4'b1111, 4'b1111, 1);
      drive(1, 4'b0100, 4'b0000, 0, 4'b0000, 0, 4'b0000);
      check_all("free_send", 1, 0, 4'b0000, 4'b1111, 4'b1111, 1);
      drive(1, 4'b0100, 4'b0000, 0, 4'b0000, 0, 4'b0100);
      check_all("free_send", 2, 0, 4'b0000, 4'b1111, 4'b1111, 1);
      drive(1, 4'b0100, 4'b0000, 0, 4'b0000, 0, 4'b0000);
      check_all("free_send", 3, 1, 4'b0100, 4'b1111, 4'b1011, 1);
      drive(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
